// File: rtl/lsu_mem_initiator_if.sv
// Pipeline request/response and data-memory port bundle for the MEM-stage load/store initiator.
// The slave modport is the initiator; the master modport is the pipeline plus memory side.
interface lsu_mem_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_type;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        resp_err;
    logic        busy;

    logic        dmem_mem_en;
    logic        dmem_rwe;
    logic        dmem_load_signed;
    logic [1:0]  dmem_type_access;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;

    modport master (
        output req_valid, req_store, req_type, req_signed, req_addr, req_wdata, dmem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned, resp_err, busy,
        input  dmem_mem_en, dmem_rwe, dmem_load_signed, dmem_type_access, dmem_addr, dmem_wdata
    );

    modport slave (
        input  req_valid, req_store, req_type, req_signed, req_addr, req_wdata, dmem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_misaligned, resp_err, busy,
        output dmem_mem_en, dmem_rwe, dmem_load_signed, dmem_type_access, dmem_addr, dmem_wdata
    );
endinterface

// File: rtl/lsu_mem_initiator.sv
// MEM-stage load/store initiator: aligned requests go out as one access, misaligned half/word
// requests are split into byte accesses with load data reassembled and extended.
module lsu_mem_initiator #(
    parameter int unsigned MemBytes = 1024
) (
    input logic                clk_i,
    input logic                rst_i,
    lsu_mem_initiator_if.slave lsu_io
);

    typedef enum logic [1:0] {StIdle, StAccess, StSplit, StResp} state_e;

    state_e      state_q, state_d;
    logic        store_q, store_d;
    logic [1:0]  type_q, type_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  last_q, last_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        mis_q, mis_d;
    logic        mem_en_q, mem_en_d;
    logic        rwe_q, rwe_d;
    logic        ls_q, ls_d;
    logic [1:0]  ta_q, ta_d;
    logic [31:0] daddr_q, daddr_d;
    logic [31:0] dwdata_q, dwdata_d;

    logic [2:0]  req_size;
    logic [32:0] req_end;
    logic        req_err;
    logic        req_aligned;
    logic [1:0]  cnt_inc;
    logic [31:0] assembled;

    always_comb begin
        case (lsu_io.req_type)
            2'b01:   req_size = 3'd4;
            2'b10:   req_size = 3'd2;
            default: req_size = 3'd1;
        endcase
    end

    // 33-bit end address so that a wrap past 2^32 still counts as out of range
    assign req_end     = {1'b0, lsu_io.req_addr} + 33'(req_size) - 33'd1;
    assign req_err     = (lsu_io.req_type == 2'b00) || (req_end >= 33'(MemBytes));
    assign req_aligned = (lsu_io.req_type == 2'b11) ||
                         ((lsu_io.req_type == 2'b10) && !lsu_io.req_addr[0]) ||
                         ((lsu_io.req_type == 2'b01) && (lsu_io.req_addr[1:0] == 2'b00));
    assign cnt_inc     = cnt_q + 2'd1;

    always_comb begin
        state_d   = state_q;
        store_d   = store_q;
        type_d    = type_q;
        signed_d  = signed_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        mis_d     = mis_q;
        // memory port is idle unless the next cycle is an access cycle
        mem_en_d  = 1'b0;
        rwe_d     = 1'b0;
        ls_d      = 1'b0;
        ta_d      = 2'b00;
        daddr_d   = 32'd0;
        dwdata_d  = 32'd0;
        assembled = rdata_q;

        unique case (state_q)
            StIdle: begin
                if (lsu_io.req_valid) begin
                    store_d  = lsu_io.req_store;
                    type_d   = lsu_io.req_type;
                    signed_d = lsu_io.req_signed;
                    addr_d   = lsu_io.req_addr;
                    wdata_d  = lsu_io.req_wdata;
                    cnt_d    = 2'd0;
                    last_d   = 2'(req_size - 3'd1);
                    rdata_d  = 32'd0;
                    err_d    = req_err;
                    mis_d    = 1'b0;
                    if (req_err) begin
                        state_d = StResp;
                    end else if (req_aligned) begin
                        state_d  = StAccess;
                        mem_en_d = 1'b1;
                        rwe_d    = lsu_io.req_store;
                        ls_d     = lsu_io.req_signed;
                        ta_d     = lsu_io.req_type;
                        daddr_d  = lsu_io.req_addr;
                        dwdata_d = lsu_io.req_wdata;
                    end else begin
                        state_d  = StSplit;
                        mis_d    = 1'b1;
                        mem_en_d = 1'b1;
                        rwe_d    = lsu_io.req_store;
                        ta_d     = 2'b11;
                        daddr_d  = lsu_io.req_addr;
                        dwdata_d = {24'd0, lsu_io.req_wdata[7:0]};
                    end
                end
            end
            StAccess: begin
                if (!store_q) begin
                    rdata_d = lsu_io.dmem_rdata;
                end
                state_d = StResp;
            end
            StSplit: begin
                if (!store_q) begin
                    assembled[{cnt_q, 3'b000} +: 8] = lsu_io.dmem_rdata[7:0];
                    if ((cnt_q == last_q) && (type_q == 2'b10)) begin
                        assembled[31:16] = {16{signed_q & assembled[15]}};
                    end
                    rdata_d = assembled;
                end
                if (cnt_q == last_q) begin
                    state_d = StResp;
                end else begin
                    cnt_d    = cnt_inc;
                    mem_en_d = 1'b1;
                    rwe_d    = store_q;
                    ta_d     = 2'b11;
                    daddr_d  = addr_q + {30'd0, cnt_inc};
                    dwdata_d = {24'd0, wdata_q[{cnt_inc, 3'b000} +: 8]};
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            store_q  <= 1'b0;
            type_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            cnt_q    <= 2'd0;
            last_q   <= 2'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
            mis_q    <= 1'b0;
            mem_en_q <= 1'b0;
            rwe_q    <= 1'b0;
            ls_q     <= 1'b0;
            ta_q     <= 2'b00;
            daddr_q  <= 32'd0;
            dwdata_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            store_q  <= store_d;
            type_q   <= type_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            mis_q    <= mis_d;
            mem_en_q <= mem_en_d;
            rwe_q    <= rwe_d;
            ls_q     <= ls_d;
            ta_q     <= ta_d;
            daddr_q  <= daddr_d;
            dwdata_q <= dwdata_d;
        end
    end

    // reset forces the idle handshake view even before the state register has cleared
    assign lsu_io.req_ready        = rst_i || (state_q == StIdle);
    assign lsu_io.busy             = !lsu_io.req_ready;
    assign lsu_io.resp_valid       = !rst_i && (state_q == StResp);
    assign lsu_io.resp_rdata       = rdata_q;
    assign lsu_io.resp_err         = err_q;
    assign lsu_io.resp_misaligned  = mis_q;
    assign lsu_io.dmem_mem_en      = mem_en_q;
    assign lsu_io.dmem_rwe         = rwe_q;
    assign lsu_io.dmem_load_signed = ls_q;
    assign lsu_io.dmem_type_access = ta_q;
    assign lsu_io.dmem_addr        = daddr_q;
    assign lsu_io.dmem_wdata       = dwdata_q;

endmodule
